// File: rtl/plugin_arbiter_pkg.sv
// Shared types, register offsets and helpers for the plugin arbiter and its
// MMIO register block.
package plugin_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } plugin_arb_state_e;

  typedef enum logic {
    OWN_ISA,
    OWN_MMIO
  } plugin_owner_e;

  localparam logic [7:0] PLG_OFF_OPA    = 8'h00;
  localparam logic [7:0] PLG_OFF_OPB    = 8'h04;
  localparam logic [7:0] PLG_OFF_CTRL   = 8'h08;
  localparam logic [7:0] PLG_OFF_STATUS = 8'h0C;
  localparam logic [7:0] PLG_OFF_RESULT = 8'h10;

  localparam int PLG_CTRL_START  = 0;
  localparam int PLG_CTRL_IRQ_EN = 1;
  localparam int PLG_CTRL_CLR    = 2;

  function automatic logic [31:0] apply_be(input logic [31:0] cur,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/plugin_arbiter_mmio_regs.sv
// MMIO command/status registers of the plugin arbiter: operand storage,
// START/IRQ_EN/CLR control, sticky DONE/ERR, result and registered read port.
module plugin_mmio_regs
  import plugin_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [3:0]  we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        busy,
  input  logic        mmio_active,
  input  logic        grant_mmio,
  input  logic        deliver,
  input  logic [31:0] deliver_result,
  input  logic        deliver_err,
  input  logic        plugin_busy,
  output logic        pend,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        irq
);

  logic [7:0]  offset;
  logic        wr;
  logic        rd;
  logic        ctrl_wr;
  logic        start_req;
  logic        clr_req;
  logic        irq_en;
  logic        done;
  logic        err;
  logic [31:0] result;
  logic [31:0] status;
  logic [31:0] read_mux;
  logic        unused_addr;

  assign offset      = addr[7:0];
  assign unused_addr = ^addr[31:8];
  assign wr          = enable && (we != 4'b0000);
  assign rd          = enable && (we == 4'b0000);
  assign ctrl_wr     = wr && (offset == PLG_OFF_CTRL);
  // A START while a job is queued or an MMIO job is running is dropped.
  assign start_req   = ctrl_wr && wdata[PLG_CTRL_START] && !pend && !mmio_active;
  assign clr_req     = ctrl_wr && wdata[PLG_CTRL_CLR];
  assign status      = {26'd0, plugin_busy, mmio_active, err, done, busy, pend};
  assign irq         = done && irq_en;

  always_comb begin
    read_mux = '0;
    case (offset)
      PLG_OFF_OPA:    read_mux = op_a;
      PLG_OFF_OPB:    read_mux = op_b;
      PLG_OFF_STATUS: read_mux = status;
      PLG_OFF_RESULT: read_mux = result;
      default:        read_mux = '0;
    endcase
  end

  // Completion setting DONE/ERR takes priority over a CLR in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_a   <= '0;
      op_b   <= '0;
      irq_en <= 1'b0;
      pend   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      rdata  <= '0;
    end else begin
      if (wr && (offset == PLG_OFF_OPA)) op_a <= apply_be(op_a, wdata, we);
      if (wr && (offset == PLG_OFF_OPB)) op_b <= apply_be(op_b, wdata, we);
      if (ctrl_wr) irq_en <= wdata[PLG_CTRL_IRQ_EN];
      if (grant_mmio)     pend <= 1'b0;
      else if (start_req) pend <= 1'b1;
      if (deliver) result <= deliver_result;
      done  <= deliver || (done && !clr_req);
      err   <= (deliver && deliver_err) || (err && !clr_req);
      rdata <= rd ? read_mux : '0;
    end
  end

endmodule

// File: rtl/plugin_arbiter.sv
// Round-robin arbiter sharing one multi-cycle plugin unit between the execute
// stage and an MMIO command port, with start/wait sequencing and a timeout abort.
module plugin_arbiter
  import plugin_arbiter_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RESULT     = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        isa_req_i,
  input  logic [31:0] isa_op_a_i,
  input  logic [31:0] isa_op_b_i,
  output logic        isa_done_o,
  output logic [31:0] isa_result_o,
  input  logic        enable_i,
  input  logic [3:0]  we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        irq_o,
  output logic        plugin_start_o,
  output logic [31:0] plugin_op_a_o,
  output logic [31:0] plugin_op_b_o,
  input  logic        plugin_busy_i,
  input  logic        plugin_done_i,
  input  logic [31:0] plugin_result_i
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  plugin_arb_state_e state, state_next;
  plugin_owner_e     owner, last_owner, grant_owner;
  logic              grant;
  logic              isa_req_eff;
  logic [CNT_W-1:0]  cnt;
  logic              deliver;
  logic [31:0]       deliver_result;
  logic              deliver_err;
  logic              isa_deliver_q;
  logic [31:0]       isa_result_q;
  logic              pend;
  logic [31:0]       reg_op_a;
  logic [31:0]       reg_op_b;
  logic              busy;
  logic              mmio_active;

  assign busy           = (state != IDLE);
  assign mmio_active    = busy && (owner == OWN_MMIO);
  assign plugin_start_o = (state == ISSUE);
  assign isa_done_o     = isa_deliver_q && isa_req_i;
  assign isa_result_o   = isa_done_o ? isa_result_q : '0;
  // The request still held during its own delivery cycle must not re-grant.
  assign isa_req_eff    = isa_req_i && !isa_deliver_q;

  always_comb begin
    state_next     = state;
    grant          = 1'b0;
    grant_owner    = OWN_ISA;
    deliver        = 1'b0;
    deliver_result = plugin_result_i;
    deliver_err    = 1'b0;
    case (state)
      IDLE: begin
        if (isa_req_eff && pend) begin
          grant       = 1'b1;
          grant_owner = (last_owner == OWN_ISA) ? OWN_MMIO : OWN_ISA;
        end else if (isa_req_eff) begin
          grant       = 1'b1;
          grant_owner = OWN_ISA;
        end else if (pend) begin
          grant       = 1'b1;
          grant_owner = OWN_MMIO;
        end
        if (grant) state_next = ISSUE;
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (plugin_done_i) begin
          deliver    = 1'b1;
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          deliver        = 1'b1;
          deliver_result = ERR_RESULT;
          deliver_err    = 1'b1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      owner         <= OWN_ISA;
      last_owner    <= OWN_MMIO;
      plugin_op_a_o <= '0;
      plugin_op_b_o <= '0;
      cnt           <= '0;
      isa_deliver_q <= 1'b0;
      isa_result_q  <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        owner      <= grant_owner;
        last_owner <= grant_owner;
        if (grant_owner == OWN_ISA) begin
          plugin_op_a_o <= isa_op_a_i;
          plugin_op_b_o <= isa_op_b_i;
        end else begin
          plugin_op_a_o <= reg_op_a;
          plugin_op_b_o <= reg_op_b;
        end
      end
      if (state == ISSUE)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 1'b1;
      isa_deliver_q <= deliver && (owner == OWN_ISA);
      if (deliver && (owner == OWN_ISA)) isa_result_q <= deliver_result;
    end
  end

  plugin_mmio_regs u_regs (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable_i),
    .we             (we_i),
    .addr           (addr_i),
    .wdata          (data_i),
    .rdata          (data_o),
    .busy           (busy),
    .mmio_active    (mmio_active),
    .grant_mmio     (grant && (grant_owner == OWN_MMIO)),
    .deliver        (deliver && (owner == OWN_MMIO)),
    .deliver_result (deliver_result),
    .deliver_err    (deliver_err),
    .plugin_busy    (plugin_busy_i),
    .pend           (pend),
    .op_a           (reg_op_a),
    .op_b           (reg_op_b),
    .irq            (irq_o)
  );

endmodule

// File: tb/tb_plugin_arbiter.sv
// Scoreboard bench for plugin_arbiter: directed ISA/MMIO jobs against an adder
// plugin model, with queued expectations checked by a negedge monitor.
module tb_plugin_arbiter;
  import plugin_arbiter_pkg::*;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        isa_req_i = 1'b0;
  logic [31:0] isa_op_a_i = '0;
  logic [31:0] isa_op_b_i = '0;
  logic        isa_done_o;
  logic [31:0] isa_result_o;
  logic        enable_i = 1'b0;
  logic [3:0]  we_i = '0;
  logic [31:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        irq_o;
  logic        plugin_start_o;
  logic [31:0] plugin_op_a_o;
  logic [31:0] plugin_op_b_o;
  logic        plugin_busy_i = 1'b0;
  logic        plugin_done_i = 1'b0;
  logic [31:0] plugin_result_i = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_count = 0;
  int last_start_cyc = 0;
  int last_isa_cyc = 0;
  int last_irq_cyc = 0;
  logic irq_prev = 1'b0;
  logic rd_pending = 1'b0;
  logic [31:0] isa_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] start_q[$];

  int          plug_lat = 3;
  int          plug_cnt = 0;
  logic        plug_hang = 1'b0;
  logic [31:0] plug_a = '0;
  logic [31:0] plug_b = '0;

  always #5 clk = ~clk;

  plugin_arbiter #(.TIMEOUT_CYCLES(TMO), .ERR_RESULT(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset_n(reset_n),
    .isa_req_i(isa_req_i), .isa_op_a_i(isa_op_a_i), .isa_op_b_i(isa_op_b_i),
    .isa_done_o(isa_done_o), .isa_result_o(isa_result_o),
    .enable_i(enable_i), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
    .data_o(data_o), .irq_o(irq_o),
    .plugin_start_o(plugin_start_o), .plugin_op_a_o(plugin_op_a_o),
    .plugin_op_b_o(plugin_op_b_o), .plugin_busy_i(plugin_busy_i),
    .plugin_done_i(plugin_done_i), .plugin_result_i(plugin_result_i)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic report_unexpected(input string name, input logic [31:0] actual);
    checks++;
    failures++;
    $display("[TB] FAIL %s: unexpected output 0x%08h, nothing expected", name, actual);
  endtask

  // Adder plugin: answers plug_lat cycles after a start unless told to hang.
  always @(negedge clk) begin
    plugin_done_i = 1'b0;
    if (plug_cnt > 0) begin
      plug_cnt = plug_cnt - 1;
      if (plug_cnt == 0) begin
        plugin_done_i   = 1'b1;
        plugin_result_i = plug_a + plug_b;
      end
    end
    if (plugin_start_o && !plug_hang) begin
      plug_cnt = plug_lat;
      plug_a   = plugin_op_a_o;
      plug_b   = plugin_op_b_o;
    end
    plugin_busy_i = (plug_cnt > 0);
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_pending <= 1'b0;
    else          rd_pending <= enable_i && (we_i == 4'b0000);
  end

  always @(negedge clk) begin
    cyc++;
    if (plugin_start_o) begin
      start_count++;
      last_start_cyc = cyc;
      if (start_q.size() == 0) report_unexpected("plugin_start", plugin_op_a_o);
      else check_output("start op_a", plugin_op_a_o, start_q.pop_front());
    end
    if (isa_done_o) begin
      last_isa_cyc = cyc;
      if (isa_q.size() == 0) report_unexpected("isa_done", isa_result_o);
      else check_output("isa_result", isa_result_o, isa_q.pop_front());
    end
    if (rd_pending) begin
      if (rd_q.size() == 0) report_unexpected("mmio read", data_o);
      else check_output("mmio read data", data_o, rd_q.pop_front());
    end
    if (irq_o && !irq_prev) last_irq_cyc = cyc;
    irq_prev = irq_o;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] off, input logic [3:0] be, input logic [31:0] d);
    enable_i = 1'b1;
    we_i     = be;
    addr_i   = 32'h1000_0000 | {24'd0, off};
    data_i   = d;
    tick(1);
    enable_i = 1'b0;
    we_i     = '0;
    data_i   = '0;
  endtask

  task automatic bus_read(input logic [7:0] off, input logic [31:0] expected);
    enable_i = 1'b1;
    we_i     = '0;
    addr_i   = 32'h1000_0000 | {24'd0, off};
    rd_q.push_back(expected);
    tick(1);
    enable_i = 1'b0;
  endtask

  task automatic wait_isa_done(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (isa_done_o) found = 1'b1;
    end
    if (!found) report_unexpected({name, " timed out waiting isa_done"}, 32'd0);
    tick(1);
  endtask

  task automatic wait_irq(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (irq_o) found = 1'b1;
    end
    if (!found) report_unexpected({name, " timed out waiting irq"}, 32'd0);
    tick(1);
  endtask

  task automatic wait_start(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (plugin_start_o) found = 1'b1;
    end
    if (!found) report_unexpected({name, " timed out waiting start"}, 32'd0);
    tick(1);
  endtask

  task automatic isa_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expected);
    isa_op_a_i = a;
    isa_op_b_i = b;
    isa_req_i  = 1'b1;
    isa_q.push_back(expected);
    start_q.push_back(a);
    wait_isa_done("isa_op");
    isa_req_i = 1'b0;
  endtask

  // MMIO START one cycle before the ISA request, so both meet in IDLE.
  task automatic tie(input logic [31:0] ma, input logic [31:0] mb, input logic [31:0] mres,
                     input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] ires,
                     input bit isa_first);
    bus_write(PLG_OFF_OPA, 4'hF, ma);
    bus_write(PLG_OFF_OPB, 4'hF, mb);
    if (isa_first) begin
      start_q.push_back(ia);
      start_q.push_back(ma);
    end else begin
      start_q.push_back(ma);
      start_q.push_back(ia);
    end
    bus_write(PLG_OFF_CTRL, 4'h1, 32'h3);
    isa_op_a_i = ia;
    isa_op_b_i = ib;
    isa_req_i  = 1'b1;
    isa_q.push_back(ires);
    wait_isa_done("tie");
    isa_req_i = 1'b0;
    wait_irq("tie");
    bus_read(PLG_OFF_RESULT, mres);
    if (isa_first) check_output("tie order isa first", 32'(last_isa_cyc < last_irq_cyc), 32'd1);
    else           check_output("tie order mmio first", 32'(last_irq_cyc < last_isa_cyc), 32'd1);
    bus_write(PLG_OFF_CTRL, 4'h1, 32'h4);
  endtask

  initial begin
    int req_cyc;
    int saved_starts;
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int req_cyc;
    int saved_starts;
    tick(3);
    check_output("reset ctrl outputs", {29'd0, isa_done_o, irq_o, plugin_start_o}, 32'd0);
    check_output("reset data_o", data_o, 32'd0);
    check_output("reset plugin_op_a", plugin_op_a_o, 32'd0);
    reset_n = 1'b1;
    tick(1);
    bus_read(PLG_OFF_STATUS, 32'h0);

    bus_write(PLG_OFF_OPA, 4'b0010, 32'h0000_AB00);
    bus_read(PLG_OFF_OPA, 32'h0000_AB00);
    tick(1);
    @(negedge clk);
    check_output("data_o idle", data_o, 32'd0);
    tick(1);
    bus_read(8'h40, 32'h0);
    bus_write(PLG_OFF_OPB, 4'hF, 32'h1234_5678);
    bus_read(PLG_OFF_OPB, 32'h1234_5678);
    bus_read(PLG_OFF_CTRL, 32'h0);

    plug_lat = 3;
    saved_starts = start_count;
    req_cyc = cyc + 1;
    isa_op(32'd5, 32'd7, 32'h0000_000C);
    check_output("isa start count", 32'(start_count - saved_starts), 32'd1);
    check_output("req to start latency", 32'(last_start_cyc - req_cyc), 32'd1);
    check_output("start to isa_done latency", 32'(last_isa_cyc - last_start_cyc), 32'd4);

    bus_write(PLG_OFF_OPA, 4'hF, 32'h10);
    bus_write(PLG_OFF_OPB, 4'hF, 32'h20);
    start_q.push_back(32'h10);
    bus_write(PLG_OFF_CTRL, 4'h1, 32'h3);
    wait_irq("mmio");
    check_output("mmio irq set", {31'd0, irq_o}, 32'd1);
    bus_read(PLG_OFF_RESULT, 32'h30);
    bus_read(PLG_OFF_STATUS, 32'h04);
    bus_write(PLG_OFF_CTRL, 4'h1, 32'h4);
    check_output("irq after clr", {31'd0, irq_o}, 32'd0);
    bus_read(PLG_OFF_STATUS, 32'h0);

    plug_lat = 2;
    tie(32'h1, 32'h2, 32'h3, 32'd100, 32'd200, 32'd300, 1'b1);
    tie(32'h40, 32'h2, 32'h42, 32'h1000, 32'h234, 32'h1234, 1'b1);
    isa_op(32'h11, 32'h22, 32'h33);
    tie(32'hA0, 32'h0B, 32'hAB, 32'h7, 32'h8, 32'hF, 1'b0);

    plug_hang = 1'b1;
    bus_write(PLG_OFF_OPA, 4'hF, 32'h55);
    start_q.push_back(32'h55);
    bus_write(PLG_OFF_CTRL, 4'h1, 32'h3);
    wait_irq("timeout");
    check_output("timeout latency", 32'(last_irq_cyc - last_start_cyc), 32'(TMO + 1));
    bus_read(PLG_OFF_RESULT, 32'hDEAD_BEEF);
    bus_read(PLG_OFF_STATUS, 32'h0C);
    plug_hang = 1'b0;
    bus_write(PLG_OFF_CTRL, 4'h1, 32'h4);
    bus_read(PLG_OFF_STATUS, 32'h0);

    plug_lat = 5;
    isa_op_a_i = 32'd9;
    isa_op_b_i = 32'd9;
    isa_req_i  = 1'b1;
    start_q.push_back(32'd9);
    wait_start("flush");
    bus_read(PLG_OFF_STATUS, 32'h22);
    isa_req_i = 1'b0;
    tick(10);
    isa_op(32'd3, 32'd4, 32'd7);

    plug_lat = 6;
    bus_write(PLG_OFF_OPA, 4'hF, 32'h77);
    start_q.push_back(32'h77);
    bus_write(PLG_OFF_CTRL, 4'h1, 32'h3);
    wait_start("reset");
    tick(1);
    reset_n = 1'b0;
    #1;
    check_output("reset mid-op ctrl outputs", {29'd0, isa_done_o, irq_o, plugin_start_o}, 32'd0);
    check_output("reset mid-op data_o", data_o, 32'd0);
    check_output("reset mid-op op_a", plugin_op_a_o, 32'd0);
    check_output("reset mid-op op_b", plugin_op_b_o, 32'd0);
    saved_starts = start_count;
    tick(1);
    reset_n = 1'b1;
    tick(10);
    check_output("irq after stray done", {31'd0, irq_o}, 32'd0);
    bus_read(PLG_OFF_STATUS, 32'h0);
    bus_read(PLG_OFF_RESULT, 32'h0);
    bus_read(PLG_OFF_OPA, 32'h0);
    check_output("no start after reset", 32'(start_count - saved_starts), 32'd0);
    tick(3);

    check_output("isa queue drained", 32'(isa_q.size()), 32'd0);
    check_output("read queue drained", 32'(rd_q.size()), 32'd0);
    check_output("start queue drained", 32'(start_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
